viterbi_ber_monitor: RTL and testbench
======================================

VITERBI_BER_MONITOR -- requirements
Module: viterbi_ber_monitor

Interface
REQ-001 Parameter MAX_LAT, default 64, meaning depth of reference-bit history and maximum detectable latency (values 0..MAX_LAT-1).
REQ-002 Parameter LOCK_WIN, default 32, meaning consecutive matches needed to declare lock and length of the loss-detection window.
REQ-003 Parameter LOSS_THR, default 8, meaning errors within one LOCK_WIN window that force loss of lock.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port ref_valid_i, input, 1 bit: ref_bit_i carries a transmitted information bit this cycle.
REQ-007 The block SHALL have the port ref_bit_i, input, 1 bit: information bit fed to the encoder.
REQ-008 The block SHALL have the port dec_valid_i, input, 1 bit: dec_bit_i carries a decoded bit this cycle.
REQ-009 The block SHALL have the port dec_bit_i, input, 1 bit: decoder output bit.
REQ-010 The block SHALL have the port clear_i, input, 1 bit: synchronous clear of the statistics.
REQ-011 The block SHALL have the port locked_o, output, 1 bit: alignment found.
REQ-012 The block SHALL have the port latency_o, output, 8 bits: current candidate latency L, counted in reference bits.
REQ-013 The block SHALL have the port bit_count_o, output, 32 bits: number of decoded bits compared while locked.
REQ-014 The block SHALL have the port error_count_o, output, 32 bits: number of mismatches while locked.
REQ-015 The block SHALL have the port overflow_o, output, 1 bit: sticky flag, set when either counter saturated.

Function
REQ-016 History: on ref_valid_i, hist shifts one place and ref_bit_i enters hist[0]; fill count increments and saturates at MAX_LAT.
REQ-017 Compare: on dec_valid_i, dec_bit_i is compared with hist[L] taken before any same-cycle shift; a dec bit arriving while fill <= L is ignored entirely.
REQ-018 The FSM SHALL have exactly two states, SEARCH and LOCKED; reset state is SEARCH.
REQ-019 SEARCH, on a match: match_cnt increments; when match_cnt reaches LOCK_WIN, the FSM enters LOCKED and clears the window counters.
REQ-020 SEARCH, on a mismatch: match_cnt clears; L increments, wrapping from MAX_LAT-1 to 0.
REQ-021 SEARCH: bit_count_o and error_count_o SHALL NOT change.
REQ-022 LOCKED, per compared bit: bit_count increments; error_count increments on mismatch; win_bits increments; win_errs increments on mismatch.
REQ-023 LOCKED, when win_errs reaches LOSS_THR: the FSM enters SEARCH, L increments with wrap, and match_cnt and window counters clear; the counting of that final bit still takes effect.
REQ-024 LOCKED, when win_bits reaches LOCK_WIN without loss: the window counters restart at 0.
REQ-025 Counters saturate at 0xFFFFFFFF; any increment attempted at saturation sets overflow_o.
REQ-026 clear_i zeroes bit_count, error_count and overflow_o; it does not alter the FSM state, L or hist; clear_i wins over a same-cycle increment.
REQ-027 locked_o is registered and high exactly while in LOCKED; latency_o reflects L with zero additional delay.
REQ-028 Simultaneous ref_valid_i and dec_valid_i SHALL both be honoured in one cycle, per REQ-017.

Reset
REQ-029 While rst is high: locked_o=0, latency_o=0, bit_count_o=0, error_count_o=0, overflow_o=0; hist, fill, match_cnt and window counters are 0; the FSM is in SEARCH.
REQ-030 Reset asserted mid-operation SHALL abort lock immediately (asynchronously); after release, the search restarts at L=0 with an empty history.

Verification
REQ-031 Error-free stream with a fixed delay of 20 bits, 300 ref bits -> locked_o=1, latency_o=20 after 32 matches; bit_count_o equals the compared bits after lock; error_count_o=0.
REQ-032 Delay 20, with dec bits inverted at positions 8 and 9 of every 16 after lock, 256 locked bits -> error_count_o=32 and lock held (4 errors per window < 8).
REQ-033 Locked, then a burst of 8 consecutive inverted dec bits -> locked_o falls on the 8th error; latency_o=21; error_count_o increased by exactly 8.
REQ-034 Latency 63, then 64 (out of range) -> locks at 63; for 64, L cycles 0..63 repeatedly and locked_o stays 0.
REQ-035 Counters preloaded near saturation via a long run (or forced) -> held at 0xFFFFFFFF with overflow_o=1; clear_i -> 0 and overflow_o=0, locked_o unchanged.
REQ-036 rst pulsed while locked -> all outputs 0 in the same cycle; relock after release requires 32 fresh matches.

Source files
------------

// File: rtl/viterbi_ber_monitor.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_ber_monitor
// Brief    : Aligns decoded bits against a reference-bit history, locks on the
//            decoder latency and counts bit errors while locked.
// Revision : 1.0 - initial release
// ============================================================================

module viterbi_ber_monitor #(
  parameter int MAX_LAT  = 64,
  parameter int LOCK_WIN = 32,
  parameter int LOSS_THR = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_valid_i,
  input  logic        ref_bit_i,
  input  logic        dec_valid_i,
  input  logic        dec_bit_i,
  input  logic        clear_i,
  output logic        locked_o,
  output logic [7:0]  latency_o,
  output logic [31:0] bit_count_o,
  output logic [31:0] error_count_o,
  output logic        overflow_o
);

  localparam int          c_IDX_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int          c_FILL_W  = $clog2(MAX_LAT + 1);
  localparam int          c_WIN_W   = $clog2(LOCK_WIN + 1);
  localparam int          c_THR_W   = $clog2(LOSS_THR + 1);
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [MAX_LAT-1:0]   r_hist;
  logic [c_FILL_W-1:0]  r_fill;
  logic [7:0]           r_lat;
  logic [7:0]           w_lat_nxt;
  logic [c_WIN_W-1:0]   r_match_cnt;
  logic [c_WIN_W-1:0]   w_match_nxt;
  logic [c_WIN_W-1:0]   r_win_bits;
  logic [c_WIN_W-1:0]   w_win_bits_nxt;
  logic [c_THR_W-1:0]   r_win_errs;
  logic [c_THR_W-1:0]   w_win_errs_nxt;
  logic [31:0]          r_bit_count;
  logic [31:0]          w_bit_count_nxt;
  logic [31:0]          r_error_count;
  logic [31:0]          w_error_count_nxt;
  logic                 r_overflow;
  logic                 w_overflow_nxt;

  logic                 w_cmp;
  logic                 w_ref_bit;
  logic                 w_mismatch;
  logic [7:0]           w_lat_inc;

  // A decoded bit only counts once the history is deep enough to hold hist[L].
  assign w_cmp      = dec_valid_i && (32'(r_fill) > 32'(r_lat));
  assign w_ref_bit  = r_hist[r_lat[c_IDX_W-1:0]];
  assign w_mismatch = dec_bit_i ^ w_ref_bit;
  assign w_lat_inc  = (r_lat == 8'(MAX_LAT - 1)) ? 8'd0 : r_lat + 8'd1;

  always_comb begin
    w_state_nxt       = r_state;
    w_lat_nxt         = r_lat;
    w_match_nxt       = r_match_cnt;
    w_win_bits_nxt    = r_win_bits;
    w_win_errs_nxt    = r_win_errs;
    w_bit_count_nxt   = r_bit_count;
    w_error_count_nxt = r_error_count;
    w_overflow_nxt    = r_overflow;

    if (w_cmp) begin
      case (r_state)
        SEARCH: begin
          if (w_mismatch) begin
            w_match_nxt = '0;
            w_lat_nxt   = w_lat_inc;
          end else if (r_match_cnt == c_WIN_W'(LOCK_WIN - 1)) begin
            w_state_nxt    = LOCKED;
            w_match_nxt    = '0;
            w_win_bits_nxt = '0;
            w_win_errs_nxt = '0;
          end else begin
            w_match_nxt = r_match_cnt + c_WIN_W'(1);
          end
        end

        LOCKED: begin
          if (r_bit_count == c_CNT_MAX) w_overflow_nxt = 1'b1;
          else                          w_bit_count_nxt = r_bit_count + 32'd1;
          if (w_mismatch) begin
            if (r_error_count == c_CNT_MAX) w_overflow_nxt = 1'b1;
            else                            w_error_count_nxt = r_error_count + 32'd1;
          end
          w_win_bits_nxt = r_win_bits + c_WIN_W'(1);
          w_win_errs_nxt = r_win_errs + c_THR_W'(w_mismatch);
          // Loss takes priority over a window that closes on the same bit.
          if (w_mismatch && (r_win_errs == c_THR_W'(LOSS_THR - 1))) begin
            w_state_nxt    = SEARCH;
            w_lat_nxt      = w_lat_inc;
            w_match_nxt    = '0;
            w_win_bits_nxt = '0;
            w_win_errs_nxt = '0;
          end else if (r_win_bits == c_WIN_W'(LOCK_WIN - 1)) begin
            w_win_bits_nxt = '0;
            w_win_errs_nxt = '0;
          end
        end

        default: w_state_nxt = SEARCH;
      endcase
    end

    if (clear_i) begin
      w_bit_count_nxt   = '0;
      w_error_count_nxt = '0;
      w_overflow_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= SEARCH;
      r_lat         <= '0;
      r_match_cnt   <= '0;
      r_win_bits    <= '0;
      r_win_errs    <= '0;
      r_bit_count   <= '0;
      r_error_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lat         <= w_lat_nxt;
      r_match_cnt   <= w_match_nxt;
      r_win_bits    <= w_win_bits_nxt;
      r_win_errs    <= w_win_errs_nxt;
      r_bit_count   <= w_bit_count_nxt;
      r_error_count <= w_error_count_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (ref_valid_i) begin
      r_hist <= {r_hist[MAX_LAT-2:0], ref_bit_i};
      if (r_fill != c_FILL_W'(MAX_LAT)) r_fill <= r_fill + c_FILL_W'(1);
    end
  end

  assign locked_o      = (r_state == LOCKED);
  assign latency_o     = r_lat;
  assign bit_count_o   = r_bit_count;
  assign error_count_o = r_error_count;
  assign overflow_o    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_ber_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_ber_monitor
// Brief    : Random-stimulus bench for viterbi_ber_monitor with a queue-based
//            reference model of alignment, lock and error counting.
// Revision : 1.0 - initial release
// ============================================================================

module tb_viterbi_ber_monitor;

  localparam int     MAX_LAT  = 64;
  localparam int     LOCK_WIN = 32;
  localparam int     LOSS_THR = 8;
  localparam longint c_MAX32  = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i;
  logic        locked_o;
  logic [7:0]  latency_o;
  logic [31:0] bit_count_o, error_count_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  viterbi_ber_monitor #(
    .MAX_LAT (MAX_LAT),
    .LOCK_WIN(LOCK_WIN),
    .LOSS_THR(LOSS_THR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ref_valid_i  (ref_valid_i),
    .ref_bit_i    (ref_bit_i),
    .dec_valid_i  (dec_valid_i),
    .dec_bit_i    (dec_bit_i),
    .clear_i      (clear_i),
    .locked_o     (locked_o),
    .latency_o    (latency_o),
    .bit_count_o  (bit_count_o),
    .error_count_o(error_count_o),
    .overflow_o   (overflow_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: full list of reference bits since reset plus lock bookkeeping.
  bit     ref_q[$];
  bit     m_locked;
  int     m_lat, m_match, m_wbits, m_werrs;
  longint m_bits, m_errs;
  bit     m_ovf;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    ref_q.delete();
    m_locked = 0; m_lat = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
    m_bits = 0; m_errs = 0; m_ovf = 0;
  endfunction

  function automatic void model_step(bit rv, bit rb, bit dv, bit db, bit clr);
    int n;
    int fill;
    bit err;
    n    = ref_q.size();
    fill = (n < MAX_LAT) ? n : MAX_LAT;
    if (dv && fill > m_lat) begin
      err = (db != ref_q[n-1-m_lat]);
      if (!m_locked) begin
        if (err) begin
          m_match = 0;
          m_lat   = (m_lat + 1) % MAX_LAT;
        end else begin
          m_match++;
          if (m_match == LOCK_WIN) begin
            m_locked = 1; m_match = 0; m_wbits = 0; m_werrs = 0;
          end
        end
      end else begin
        if (m_bits == c_MAX32) m_ovf = 1; else m_bits++;
        if (err) begin
          if (m_errs == c_MAX32) m_ovf = 1; else m_errs++;
        end
        m_wbits++;
        m_werrs += int'(err);
        if (m_werrs == LOSS_THR) begin
          m_locked = 0; m_lat = (m_lat + 1) % MAX_LAT;
          m_match = 0; m_wbits = 0; m_werrs = 0;
        end else if (m_wbits == LOCK_WIN) begin
          m_wbits = 0; m_werrs = 0;
        end
      end
    end
    if (rv) ref_q.push_back(rb);
    if (clr) begin
      m_bits = 0; m_errs = 0; m_ovf = 0;
    end
  endfunction

  task automatic check_outputs();
    check_val("locked",  64'(locked_o),      64'(m_locked));
    check_val("latency", 64'(latency_o),     64'(m_lat));
    check_val("bits",    64'(bit_count_o),   m_bits);
    check_val("errs",    64'(error_count_o), m_errs);
    check_val("ovf",     64'(overflow_o),    64'(m_ovf));
  endtask

  // Drive at the falling edge, update the model at the rising edge, check at the next fall.
  task automatic cycle(input bit rv, input bit rb, input bit dv, input bit db, input bit clr);
    ref_valid_i = rv; ref_bit_i = rb; dec_valid_i = dv; dec_bit_i = db; clear_i = clr;
    @(posedge clk);
    model_step(rv, rb, dv, db, clr);
    @(negedge clk);
    ref_valid_i = 0; dec_valid_i = 0; clear_i = 0;
    check_outputs();
  endtask

  // One new reference bit plus the decoded copy of the bit sent 'delay' positions earlier.
  task automatic pair(input int delay, input bit inv, input bit clr);
    int n;
    bit rb;
    if ($urandom_range(7) == 0) cycle(0, 0, 0, 0, 0);
    n  = ref_q.size();
    rb = 1'($urandom_range(1));
    if (n - 1 - delay >= 0) cycle(1, rb, 1, ref_q[n-1-delay] ^ inv, clr);
    else                    cycle(1, rb, 0, 0, clr);
  endtask

  task automatic do_reset();
    rst = 1;
    ref_valid_i = 0; dec_valid_i = 0; clear_i = 0;
    #1;
    model_reset();
    check_val("rst_locked",  64'(locked_o),      0);
    check_val("rst_latency", 64'(latency_o),     0);
    check_val("rst_bits",    64'(bit_count_o),   0);
    check_val("rst_errs",    64'(error_count_o), 0);
    check_val("rst_ovf",     64'(overflow_o),    0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    longint e0;
    int     k_lock;
    bit     saw_lock, saw_wrap;
    logic [7:0] prev_lat;

    rst = 1; ref_valid_i = 0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0; clear_i = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Error-free stream at delay 20.
    for (int i = 0; i < 300; i++) pair(20, 0, 0);
    check_val("d20_locked",  64'(locked_o),      1);
    check_val("d20_latency", 64'(latency_o),     20);
    check_val("d20_errs",    64'(error_count_o), 0);

    // Two errors in every 16 locked bits: 4 per window, lock must hold.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 256; i++) pair(20, (i % 16 == 8) || (i % 16 == 9), 0);
    check_val("pat_errs",   64'(error_count_o), 32);
    check_val("pat_bits",   64'(bit_count_o),   256);
    check_val("pat_locked", 64'(locked_o),      1);

    // Clean windows, then a burst of 8 errors drops lock on the 8th.
    for (int i = 0; i < 64; i++) pair(20, 0, 0);
    e0 = 64'(error_count_o);
    for (int i = 0; i < 8; i++) begin
      pair(20, 1, 0);
      check_val("burst_locked", 64'(locked_o), (i < 7) ? 1 : 0);
    end
    check_val("burst_latency", 64'(latency_o), 21);
    check_val("burst_delta",   64'(error_count_o) - e0, 8);

    // Relock by wrapping the search back round to 20.
    for (int i = 0; i < 400; i++) pair(20, 0, 0);
    check_val("relock_locked",  64'(locked_o),  1);
    check_val("relock_latency", 64'(latency_o), 20);

    // Saturation: preload counters just below / at the limit.
    force dut.r_bit_count   = 32'hFFFF_FFFE;
    force dut.r_error_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_bit_count;
    release dut.r_error_count;
    m_bits = 64'h0000_0000_FFFF_FFFE;
    m_errs = c_MAX32;
    pair(20, 0, 0);
    check_val("sat_ovf0", 64'(overflow_o), 0);
    pair(20, 0, 0);
    check_val("sat_bits", 64'(bit_count_o), 64'hFFFF_FFFF);
    check_val("sat_ovf1", 64'(overflow_o),  1);
    pair(20, 1, 0);
    check_val("sat_errs", 64'(error_count_o), 64'hFFFF_FFFF);
    pair(20, 0, 1);
    check_val("clr_bits",   64'(bit_count_o),   0);
    check_val("clr_errs",   64'(error_count_o), 0);
    check_val("clr_ovf",    64'(overflow_o),    0);
    check_val("clr_locked", 64'(locked_o),      1);

    // Asynchronous reset while locked, then a fresh search.
    #2;
    rst = 1;
    #1;
    model_reset();
    check_val("arst_locked",  64'(locked_o),      0);
    check_val("arst_latency", 64'(latency_o),     0);
    check_val("arst_bits",    64'(bit_count_o),   0);
    check_val("arst_errs",    64'(error_count_o), 0);
    check_val("arst_ovf",     64'(overflow_o),    0);
    @(negedge clk);
    rst = 0;
    k_lock = -1;
    for (int i = 0; i < 400; i++) begin
      pair(20, 0, 0);
      if (locked_o && k_lock < 0) k_lock = i;
    end
    check_val("arst_relock_min", 64'(k_lock >= 21 + LOCK_WIN - 1), 1);
    check_val("arst_relock_lat", 64'(latency_o), 20);

    // Deepest supported latency.
    do_reset();
    for (int i = 0; i < 500; i++) pair(63, 0, 0);
    check_val("d63_locked",  64'(locked_o),  1);
    check_val("d63_latency", 64'(latency_o), 63);

    // Out-of-range latency: search wraps forever without locking.
    do_reset();
    saw_lock = 0; saw_wrap = 0; prev_lat = 8'd0;
    for (int i = 0; i < 800; i++) begin
      pair(64, 0, 0);
      if (locked_o) saw_lock = 1;
      if (prev_lat == 8'd63 && latency_o == 8'd0) saw_wrap = 1;
      prev_lat = latency_o;
    end
    check_val("d64_nolock", 64'(saw_lock), 0);
    check_val("d64_wrap",   64'(saw_wrap), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
